// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction fetch that streams sequential words into a circular instruction queue.
// Build option FETCH_QUEUE_BYPASS_EN forwards a clean response straight to the head outputs when the queue is empty.

`ifndef MEM_ACCESS
`define MEM_ACCESS [1:0]
`define MEM_ACCESS_NONE 2'd0
`define MEM_ACCESS_R 2'd1
`define MEM_ACCESS_W 2'd2
`define MEM_ACCESS_X 2'd3
`endif

`ifndef MEM_LEN
`define MEM_LEN [1:0]
`define MEM_LEN_B 2'd0
`define MEM_LEN_H 2'd1
`define MEM_LEN_W 2'd2
`endif

`ifndef MMU_EXCEPTION
`define MMU_EXCEPTION [1:0]
`define MMU_EXCEPTION_NONE 2'd0
`define MMU_EXCEPTION_TLB_MISS 2'd1
`define MMU_EXCEPTION_TLB_INVALID 2'd2
`define MMU_EXCEPTION_ADDR_ERROR 2'd3
`endif

module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                         clk,
    input  logic                         res,
    output logic [31:0]                  db_addr,
    output logic `MEM_ACCESS             db_accessType,
    output logic `MEM_LEN                db_memLen,
    input  logic [31:0]                  db_dataIn,
    input  logic                         db_ready,
    input  logic `MMU_EXCEPTION          mmu_exception,
    output logic                         ins_valid,
    output logic [31:0]                  ins,
    output logic [31:0]                  ins_pc,
    output logic `MMU_EXCEPTION          ins_exc,
    input  logic                         ins_take,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state_r;
    logic [31:0]       fpc_r;
    logic [31:0]       drain_pc_r;
    logic              req_r;
    logic [CW-1:0]     count_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [31:0]       mem_ins_r [DEPTH];
    logic [31:0]       mem_pc_r  [DEPTH];
    logic `MMU_EXCEPTION mem_exc_r [DEPTH];
    logic              head_valid_r;
    logic [31:0]       head_ins_r;
    logic [31:0]       head_pc_r;
    logic `MMU_EXCEPTION head_exc_r;

    logic              resp_s;
    logic              clean_s;
    logic              flush_s;
    logic              bypass_s;
    logic              push_s;
    logic              pop_s;
    logic [31:0]       push_ins_s;
    state_t            state_n_s;
    logic [31:0]       fpc_n_s;
    logic [31:0]       drain_pc_n_s;
    logic              req_n_s;
    logic [CW-1:0]     count_n_s;
    logic [PW-1:0]     rd_ptr_n_s;
    logic [PW-1:0]     wr_ptr_n_s;
    logic              head_valid_n_s;
    logic [31:0]       head_ins_n_s;
    logic [31:0]       head_pc_n_s;
    logic `MMU_EXCEPTION head_exc_n_s;

    // Bus handshake decode: response completion, flush, bypass and queue push/pop qualifiers.
    always_comb begin
        resp_s     = req_r && (db_ready || (mmu_exception != `MMU_EXCEPTION_NONE));
        clean_s    = resp_s && (mmu_exception == `MMU_EXCEPTION_NONE);
        flush_s    = redirect && (state_r != S_INIT);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s   = clean_s && !flush_s && (state_r == S_FETCH) && (count_r == {CW{1'b0}});
`else
        bypass_s   = 1'b0;
`endif
        push_s     = !flush_s && (state_r == S_FETCH) && resp_s && !(bypass_s && ins_take);
        pop_s      = !flush_s && ins_take && head_valid_r;
        push_ins_s = clean_s ? db_dataIn : 32'h0000_0000;
    end

    // Fetch sequencing: next state, fetch PC and the PC saved while draining an unabortable fetch.
    always_comb begin
        state_n_s    = state_r;
        fpc_n_s      = fpc_r;
        drain_pc_n_s = drain_pc_r;
        if (flush_s) begin
            if (req_r && !resp_s) begin
                state_n_s    = S_DRAIN;
                drain_pc_n_s = redirect_pc;
            end else begin
                state_n_s = S_FETCH;
                fpc_n_s   = redirect_pc;
            end
        end else begin
            case (state_r)
                S_INIT: begin
                    state_n_s = S_FETCH;
                end
                S_FETCH: begin
                    if (clean_s) begin
                        fpc_n_s = fpc_r + 32'd4;
                    end else if (resp_s) begin
                        state_n_s = S_HALT;
                    end else begin
                        state_n_s = S_FETCH;
                    end
                end
                S_HALT: begin
                    state_n_s = S_HALT;
                end
                S_DRAIN: begin
                    if (resp_s) begin
                        state_n_s = S_FETCH;
                        fpc_n_s   = drain_pc_r;
                    end else begin
                        state_n_s = S_DRAIN;
                    end
                end
                default: begin
                    state_n_s = S_INIT;
                end
            endcase
        end
    end

    // Queue bookkeeping and the next head entry, forwarding a push that lands on the new head slot.
    always_comb begin
        count_n_s  = count_r;
        rd_ptr_n_s = rd_ptr_r;
        wr_ptr_n_s = wr_ptr_r;
        if (flush_s) begin
            count_n_s  = {CW{1'b0}};
            rd_ptr_n_s = {PW{1'b0}};
            wr_ptr_n_s = {PW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_n_s = count_r + CW'(1'b1);
                2'b01:   count_n_s = count_r - CW'(1'b1);
                default: count_n_s = count_r;
            endcase
            if (push_s) begin
                wr_ptr_n_s = wr_ptr_r + PW'(1'b1);
            end else begin
                wr_ptr_n_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_n_s = rd_ptr_r + PW'(1'b1);
            end else begin
                rd_ptr_n_s = rd_ptr_r;
            end
        end

        req_n_s        = (state_n_s == S_DRAIN) || ((state_n_s == S_FETCH) && (count_n_s != FULL_COUNT));
        head_valid_n_s = (count_n_s != {CW{1'b0}});
        if (push_s && (wr_ptr_r == rd_ptr_n_s)) begin
            head_ins_n_s = push_ins_s;
            head_pc_n_s  = fpc_r;
            head_exc_n_s = mmu_exception;
        end else begin
            head_ins_n_s = mem_ins_r[rd_ptr_n_s];
            head_pc_n_s  = mem_pc_r[rd_ptr_n_s];
            head_exc_n_s = mem_exc_r[rd_ptr_n_s];
        end
    end

    // State, queue storage and registered head entry.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_r      <= S_INIT;
            fpc_r        <= RESET_PC;
            drain_pc_r   <= RESET_PC;
            req_r        <= 1'b0;
            count_r      <= {CW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            head_valid_r <= 1'b0;
            head_ins_r   <= 32'h0000_0000;
            head_pc_r    <= 32'h0000_0000;
            head_exc_r   <= `MMU_EXCEPTION_NONE;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_ins_r[i] <= 32'h0000_0000;
                mem_pc_r[i]  <= 32'h0000_0000;
                mem_exc_r[i] <= `MMU_EXCEPTION_NONE;
            end
        end else begin
            state_r      <= state_n_s;
            fpc_r        <= fpc_n_s;
            drain_pc_r   <= drain_pc_n_s;
            req_r        <= req_n_s;
            count_r      <= count_n_s;
            rd_ptr_r     <= rd_ptr_n_s;
            wr_ptr_r     <= wr_ptr_n_s;
            head_valid_r <= head_valid_n_s;
            head_ins_r   <= head_ins_n_s;
            head_pc_r    <= head_pc_n_s;
            head_exc_r   <= head_exc_n_s;
            if (push_s) begin
                mem_ins_r[wr_ptr_r] <= push_ins_s;
                mem_pc_r[wr_ptr_r]  <= fpc_r;
                mem_exc_r[wr_ptr_r] <= mmu_exception;
            end
        end
    end

    // Output drive; fpc doubles as the held address of an outstanding fetch.
    always_comb begin
        db_addr       = fpc_r;
        db_accessType = req_r ? `MEM_ACCESS_X : `MEM_ACCESS_NONE;
        db_memLen     = `MEM_LEN_W;
        count         = count_r;
        if (bypass_s) begin
            ins_valid = 1'b1;
            ins       = db_dataIn;
            ins_pc    = fpc_r;
            ins_exc   = `MMU_EXCEPTION_NONE;
        end else begin
            ins_valid = head_valid_r;
            ins       = head_ins_r;
            ins_pc    = head_pc_r;
            ins_exc   = head_exc_r;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected entries are queued as the bench completes fetches
// and compared as the bench pops the instruction head; directed scenarios plus a random phase.

`ifndef MEM_ACCESS
`define MEM_ACCESS [1:0]
`define MEM_ACCESS_NONE 2'd0
`define MEM_ACCESS_R 2'd1
`define MEM_ACCESS_W 2'd2
`define MEM_ACCESS_X 2'd3
`endif

`ifndef MEM_LEN
`define MEM_LEN [1:0]
`define MEM_LEN_B 2'd0
`define MEM_LEN_H 2'd1
`define MEM_LEN_W 2'd2
`endif

`ifndef MMU_EXCEPTION
`define MMU_EXCEPTION [1:0]
`define MMU_EXCEPTION_NONE 2'd0
`define MMU_EXCEPTION_TLB_MISS 2'd1
`define MMU_EXCEPTION_TLB_INVALID 2'd2
`define MMU_EXCEPTION_ADDR_ERROR 2'd3
`endif

module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [1:0] EXC_NONE = `MMU_EXCEPTION_NONE;
    localparam logic [1:0] EXC_TLB  = `MMU_EXCEPTION_TLB_MISS;

    logic                clk = 1'b0;
    logic                res;
    logic [31:0]         db_addr;
    logic `MEM_ACCESS    db_accessType;
    logic `MEM_LEN       db_memLen;
    logic [31:0]         db_dataIn;
    logic                db_ready;
    logic `MMU_EXCEPTION mmu_exception;
    logic                ins_valid;
    logic [31:0]         ins;
    logic [31:0]         ins_pc;
    logic `MMU_EXCEPTION ins_exc;
    logic                ins_take;
    logic                redirect;
    logic [31:0]         redirect_pc;
    logic [CW-1:0]       count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h8000_0000)) dut (
        .clk          (clk),
        .res          (res),
        .db_addr      (db_addr),
        .db_accessType(db_accessType),
        .db_memLen    (db_memLen),
        .db_dataIn    (db_dataIn),
        .db_ready     (db_ready),
        .mmu_exception(mmu_exception),
        .ins_valid    (ins_valid),
        .ins          (ins),
        .ins_pc       (ins_pc),
        .ins_exc      (ins_exc),
        .ins_take     (ins_take),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [1:0]  exc;
    } entry_t;

    entry_t      sb[$];
    logic [31:0] addr_log[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        drain_exp = 1'b0;
    logic        data_ovr_en = 1'b0;
    logic [31:0] data_ovr = 32'h0;
    logic        snap_valid;
    logic [31:0] snap_ins;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    // One clock: drive inputs, update scoreboard from the bus handshake, compare popped heads.
    task automatic cycle(input logic take, input logic rdy, input logic [1:0] exc,
                         input logic redir, input logic [31:0] rpc);
        logic   outst;
        logic   resp;
        entry_t e;
        ins_take      = take;
        db_ready      = rdy;
        mmu_exception = exc;
        redirect      = redir;
        redirect_pc   = rpc;
        db_dataIn     = data_ovr_en ? data_ovr : mem_word(db_addr);
        #1;
        outst = (db_accessType == `MEM_ACCESS_X);
        resp  = outst && (rdy || (exc != EXC_NONE));
        if (resp) addr_log.push_back(db_addr);
        if (resp && !redir && !drain_exp) begin
            e.ins = (exc == EXC_NONE) ? db_dataIn : 32'h0;
            e.pc  = db_addr;
            e.exc = exc;
            sb.push_back(e);
        end
        snap_valid = ins_valid;
        snap_ins   = ins;
        if (redir) begin
            sb.delete();
            drain_exp = outst && !resp;
        end else begin
            if (resp) drain_exp = 1'b0;
            if (take && ins_valid) begin
                check_value("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_value("pop_ins", ins, e.ins);
                    check_value("pop_pc", ins_pc, e.pc);
                    check_value("pop_exc", 32'(ins_exc), 32'(e.exc));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        res = 1'b0;
        ins_take = 1'b0; db_ready = 1'b0; mmu_exception = EXC_NONE;
        redirect = 1'b0; redirect_pc = 32'h0; db_dataIn = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_count", 32'(count), 32'd0);
        check_value("rst_valid", 32'(ins_valid), 32'd0);
        check_value("rst_access", 32'(db_accessType), 32'(`MEM_ACCESS_NONE));
        check_value("rst_addr", db_addr, 32'h8000_0000);
        check_value("memlen", 32'(db_memLen), 32'(`MEM_LEN_W));
        res = 1'b1;

        // Fill after reset with ready tied high.
        repeat (10) cycle(1'b0, 1'b1, EXC_NONE, 1'b0, 32'h0);
        check_value("fill_n", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < addr_log.size()) check_value("fill_addr", addr_log[i], 32'h8000_0000 + 32'(i * 4));
        check_value("full_count", 32'(count), 32'd4);
        check_value("full_access", 32'(db_accessType), 32'(`MEM_ACCESS_NONE));
        check_value("full_head_pc", ins_pc, 32'h8000_0000);
        check_value("full_valid", 32'(ins_valid), 32'd1);

        // Single pop from full queue allows exactly one new fetch.
        addr_log.delete();
        cycle(1'b1, 1'b1, EXC_NONE, 1'b0, 32'h0);
        repeat (4) cycle(1'b0, 1'b1, EXC_NONE, 1'b0, 32'h0);
        check_value("refill_n", 32'(addr_log.size()), 32'd1);
        if (addr_log.size() != 0) check_value("refill_addr", addr_log[0], 32'h8000_0010);
        check_value("refill_count", 32'(count), 32'd4);

        // Redirect while a fetch is outstanding: drain, last redirect wins.
        cycle(1'b0, 1'b1, EXC_NONE, 1'b1, 32'h8000_0000);
        repeat (2) cycle(1'b0, 1'b1, EXC_NONE, 1'b0, 32'h0);
        check_value("out_addr", db_addr, 32'h8000_0008);
        check_value("out_access", 32'(db_accessType), 32'(`MEM_ACCESS_X));
        cycle(1'b0, 1'b0, EXC_NONE, 1'b1, 32'h8000_3000);
        check_value("drain_addr", db_addr, 32'h8000_0008);
        check_value("drain_access", 32'(db_accessType), 32'(`MEM_ACCESS_X));
        check_value("drain_count", 32'(count), 32'd0);
        check_value("drain_valid", 32'(ins_valid), 32'd0);
        cycle(1'b0, 1'b0, EXC_NONE, 1'b1, 32'h8000_1000);
        cycle(1'b0, 1'b0, EXC_NONE, 1'b0, 32'h0);
        check_value("drain_hold", db_addr, 32'h8000_0008);
        cycle(1'b0, 1'b1, EXC_NONE, 1'b0, 32'h0);
        check_value("redir_addr", db_addr, 32'h8000_1000);
        check_value("redir_count", 32'(count), 32'd0);
        cycle(1'b0, 1'b1, EXC_NONE, 1'b0, 32'h0);
        check_value("redir_head_pc", ins_pc, 32'h8000_1000);
        repeat (3) cycle(1'b1, 1'b0, EXC_NONE, 1'b0, 32'h0);

        // MMU exception halts fetching until a redirect.
        cycle(1'b0, 1'b1, EXC_NONE, 1'b1, 32'h8000_0000);
        check_value("same_cycle_redir", db_addr, 32'h8000_0000);
        cycle(1'b0, 1'b1, EXC_NONE, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, EXC_TLB, 1'b0, 32'h0);
        addr_log.delete();
        repeat (3) cycle(1'b0, 1'b1, EXC_NONE, 1'b0, 32'h0);
        check_value("halt_nofetch", 32'(addr_log.size()), 32'd0);
        check_value("halt_access", 32'(db_accessType), 32'(`MEM_ACCESS_NONE));
        check_value("halt_count", 32'(count), 32'd2);
        cycle(1'b1, 1'b0, EXC_NONE, 1'b0, 32'h0);
        check_value("exc_pc", ins_pc, 32'h8000_0004);
        check_value("exc_tag", 32'(ins_exc), 32'(EXC_TLB));
        cycle(1'b1, 1'b0, EXC_NONE, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, EXC_NONE, 1'b1, 32'h8000_0180);
        check_value("resume_addr", db_addr, 32'h8000_0180);
        check_value("resume_access", 32'(db_accessType), 32'(`MEM_ACCESS_X));
        cycle(1'b0, 1'b1, EXC_NONE, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, EXC_NONE, 1'b0, 32'h0);

        // Fetch PC wraps at the top of the address space.
        cycle(1'b0, 1'b1, EXC_NONE, 1'b1, 32'hFFFF_FFFC);
        check_value("wrap_pre", db_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b1, EXC_NONE, 1'b0, 32'h0);
        check_value("wrap_addr", db_addr, 32'h0000_0000);
        cycle(1'b1, 1'b0, EXC_NONE, 1'b0, 32'h0);

        // Empty queue, consumer ready, clean response.
        cycle(1'b0, 1'b1, EXC_NONE, 1'b1, 32'h8000_2000);
        data_ovr_en = 1'b1;
        data_ovr    = 32'h2402_0001;
        cycle(1'b1, 1'b1, EXC_NONE, 1'b0, 32'h0);
        data_ovr_en = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        check_value("byp_valid", 32'(snap_valid), 32'd1);
        check_value("byp_ins", snap_ins, 32'h2402_0001);
        check_value("byp_count", 32'(count), 32'd0);
`else
        check_value("nobyp_valid0", 32'(snap_valid), 32'd0);
        check_value("nobyp_count", 32'(count), 32'd1);
        check_value("nobyp_valid1", 32'(ins_valid), 32'd1);
        check_value("nobyp_ins", ins, 32'h2402_0001);
`endif
        cycle(1'b1, 1'b0, EXC_NONE, 1'b0, 32'h0);

        // Random traffic with occasional redirects and exceptions.
        for (int k = 0; k < 300; k++) begin
            logic [31:0] r;
            r = $urandom;
            cycle(r[0], r[1] | r[2], (r[8:4] == 5'd0) ? EXC_TLB : EXC_NONE,
                  (r[13:9] == 5'd0), {16'h8000, r[29:16], 2'b00});
            check_value("count_bound", 32'(count <= CW'(DEPTH)), 32'd1);
        end
        repeat (2 * DEPTH + 2) cycle(1'b1, 1'b0, EXC_NONE, 1'b0, 32'h0);
        check_value("end_sb_empty", 32'(sb.size()), 32'd0);
        check_value("end_count", 32'(count), 32'd0);
        check_value("end_valid", 32'(ins_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupled instruction-fetch front end for the multicycle CPU core. Replaces the single-shot fetch state.
- Issues sequential word fetches on the data bus into a parametrised-depth instruction queue, tagged with PC and MMU exception. The core consumes from the queue.
- A redirect from branch, jump, eret or exception flushes the queue and restarts fetching at a new PC.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- RESET_PC, 32'h80000000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- res  in  1  asynchronous active-low reset (0 = reset).
- db_addr  out  32  fetch address; held stable while db_accessType is `MEM_ACCESS_X.
- db_accessType  out  `MEM_ACCESS  `MEM_ACCESS_X while a fetch is outstanding, else `MEM_ACCESS_NONE.
- db_memLen  out  `MEM_LEN  constant `MEM_LEN_W.
- db_dataIn  in  32  fetched word; valid when db_ready.
- db_ready  in  1  completes the outstanding fetch.
- mmu_exception  in  `MMU_EXCEPTION  sampled with db_ready or in place of it.
- ins_valid  out  1  head entry valid.
- ins  out  32  head instruction.
- ins_pc  out  32  PC of head entry.
- ins_exc  out  `MMU_EXCEPTION  exception tag of head; `MMU_EXCEPTION_NONE if clean.
- ins_take  in  1  pop head; ignored when !ins_valid.
- redirect  in  1  flush and restart.
- redirect_pc  in  32  new fetch PC; sampled when redirect=1.
- count  out  $clog2(DEPTH+1)  occupancy, for debug.

Behaviour:
- Reset (res=0, async):
  - state=S_INIT, fpc=RESET_PC, count=0, ins_valid=0, db_accessType=NONE.
  - All queue pointers reset to 0.
- States:
  - S_INIT: one cycle, then S_FETCH.
  - S_FETCH: request active iff count<DEPTH. db_addr=fpc, db_accessType=X.
    - db_ready with mmu_exception==NONE: push {db_dataIn, fpc, NONE}; fpc+=4 (wraps mod 2^32); stay in S_FETCH.
    - mmu_exception!=NONE (db_ready not required): push {32'h0, fpc, exc}; go to S_HALT; fpc unchanged.
    - count==DEPTH: no request; db_accessType=NONE until an entry is popped.
  - S_HALT: no requests. Queue drains normally. Leave only by redirect.
  - S_DRAIN: entered when redirect arrives while a fetch is outstanding and db_ready/exception is not asserted that same cycle.
    - Holds db_addr and db_accessType=X (the bus cannot abort).
    - On db_ready or exception: discard the response, go to S_FETCH at the saved redirect PC.
- Redirect (any state except S_INIT):
  - Queue emptied next cycle (count=0, ins_valid=0); fpc<=redirect_pc.
  - Takes priority over a simultaneous push and ins_take.
  - A response completing in the same cycle as redirect is discarded; next state is S_FETCH.
  - Redirect while in S_DRAIN updates the saved PC (last wins).
- Queue:
  - Circular buffer with $clog2(DEPTH)-bit read/write pointers and separate count.
  - Push and pop in the same cycle: count unchanged, allowed at full and at empty.
  - Head output registered from the buffer: data pushed at edge N is visible from N+1.
- Latency: redirect at edge N → request at fpc issued from cycle N+1, data available ins_valid at earliest edge after db_ready.
- Only one fetch is ever outstanding.
- db_addr when no request: fpc (don't-care for the bus).

Optional Feature:
- FETCH_QUEUE_BYPASS_EN
- Defined: when count==0, no redirect, and a clean response arrives, ins/ins_pc/ins_exc/ins_valid are driven combinationally from db_dataIn/fpc in the same cycle.
  - If ins_take is also 1 that cycle, the word is not enqueued.
  - Zero-cycle fetch-to-decode latency.
- Undefined: always enqueue; minimum one cycle from db_ready to ins_valid. Exception entries never bypass in either mode.

Test Plan:
- Reset release, db_ready tied 1, ins_take=0, DEPTH=4 → fetches 80000000, 80000004, 80000008, 8000000C.
  - Then count=4, db_accessType=NONE.
  - ins_pc=80000000.
- Full queue, pulse ins_take one cycle → exactly one new fetch at 80000010; count returns to 4.
- Redirect to 80001000 while fetch at 80000008 outstanding (db_ready delayed 3 cycles) → S_DRAIN.
  - That response is discarded; queue empty.
  - Next db_addr=80001000.
  - First ins_pc=80001000.
- mmu_exception=TLB-miss on fetch of 80000004 → entry {pc=80000004, exc≠NONE} after entry 80000000; no further requests.
  - Redirect to 80000180 resumes fetching.
- fpc=FFFFFFFC with clean response → next db_addr=00000000.
- Bypass build, empty queue, ins_take=1, response 0x24020001 → ins=0x24020001 and ins_valid=1 in the db_ready cycle; count stays 0.
  - Non-bypass build: ins_valid one cycle later, count=1.
